// File: rtl/sens_hispi_enc_pkg.sv
// Shared HiSPi Packetized-SP constants and encoder FSM encoding.
// The sync and code words are shared with the receiver lane decoder.
package sens_hispi_enc_pkg;

    localparam logic [11:0] SYNC0    = 12'hFFF;
    localparam logic [11:0] SYNC1    = 12'h000;
    localparam logic [11:0] SYNC2    = 12'h000;

    localparam logic [11:0] CODE_SOL = 12'h001;
    localparam logic [11:0] CODE_SOF = 12'h003;
    localparam logic [11:0] CODE_EOL = 12'h005;
    localparam logic [11:0] CODE_EOF = 12'h007;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_TRL  = 3'd3,
        ST_EOFP = 3'd4
    } enc_state_t;

    // Word idx of a 4-word control packet: three sync words, then the code.
    function automatic logic [11:0] ctl_word(input logic [1:0] idx, input logic [11:0] code);
        logic [11:0] w;
        case (idx)
            2'd0:    w = SYNC0;
            2'd1:    w = SYNC1;
            2'd2:    w = SYNC2;
            default: w = code;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sens_hispi_enc_gather.sv
// Pixel/hact delay line plus 4-pixel gather register; PXD_DLY cycles latency, no backpressure.
// grp shows the gathered group with the current delayed pixel bypassed in; unfilled slots read 0.
module sens_hispi_enc_gather #(
    parameter int NUMLANES = 4,
    parameter int PXD_DLY  = 16
) (
    input  logic                     ipclk,
    input  logic                     irst,
    input  logic [11:0]              pxd,
    input  logic                     hact,
    input  logic                     grp_clr,
    output logic [12*NUMLANES-1:0]   grp,
    output logic                     dly_hact
);

    logic [11:0]        pix_sr [PXD_DLY];
    logic [PXD_DLY-1:0] hact_sr;
    logic [11:0]        gbuf [NUMLANES];
    logic [11:0]        dly_pix;
    logic               dly_hact_d;
    logic               dly_rise;
    logic [1:0]         slot_q;
    logic [1:0]         cur_slot;

    assign dly_pix  = pix_sr[PXD_DLY-1];
    assign dly_hact = hact_sr[PXD_DLY-1];
    assign dly_rise = dly_hact & ~dly_hact_d;
    assign cur_slot = dly_rise ? 2'd0 : slot_q;

    always_ff @(posedge ipclk or posedge irst) begin
        if (irst) begin
            hact_sr    <= '0;
            dly_hact_d <= 1'b0;
            slot_q     <= 2'd0;
            for (int i = 0; i < PXD_DLY; i++) pix_sr[i] <= '0;
            for (int i = 0; i < NUMLANES; i++) gbuf[i] <= '0;
        end else begin
            hact_sr   <= {hact_sr[PXD_DLY-2:0], hact};
            pix_sr[0] <= pxd;
            for (int i = 1; i < PXD_DLY; i++) pix_sr[i] <= pix_sr[i-1];
            dly_hact_d <= dly_hact;
            if (dly_hact) slot_q <= cur_slot + 2'd1;

            // Clearing on emission leaves zeros behind for a short last group.
            if (grp_clr) begin
                for (int i = 0; i < NUMLANES; i++) gbuf[i] <= '0;
            end else if (dly_hact) begin
                if (dly_rise) begin
                    for (int i = 0; i < NUMLANES; i++) gbuf[i] <= '0;
                end
                gbuf[cur_slot] <= dly_pix;
            end
        end
    end

    always_comb begin
        grp = '0;
        for (int i = 0; i < NUMLANES; i++) begin
            grp[12*i +: 12] = (dly_hact && (cur_slot == 2'(i))) ? dly_pix : gbuf[i];
        end
    end

endmodule

// File: rtl/sens_hispi_enc.sv
// Pixel stream to HiSPi 4-lane Packetized-SP words; first header word 4 cycles after line start, data 20.
// No backpressure: a line start while busy is dropped and flagged on the sticky overrun output.
module sens_hispi_enc
    import sens_hispi_enc_pkg::*;
#(
    parameter int NUMLANES  = 4,
    parameter int PXD_DLY   = 16,
    parameter int EMBED_BIT = 4
) (
    input  logic                    pclk,
    input  logic                    prst,
    input  logic [11:0]             pxd_in,
    input  logic                    hact_in,
    input  logic                    vact_in,
    input  logic                    embed,
    output logic [12*NUMLANES-1:0]  lane_dout,
    output logic                    wstb,
    output logic                    busy,
    output logic                    overrun
);

    enc_state_t             state, state_nxt;
    logic [1:0]             phase, wcnt;
    logic                   hact_d, vact_d;
    logic                   first_line, eof_pend, line_acc;
    logic [11:0]            hdr_code, hdr_code_nxt;
    logic [12*NUMLANES-1:0] grp, word_nxt;
    logic                   dly_hact;
    logic                   line_start, vact_rise, vact_fall;
    logic                   last_word, emit, start_hdr, start_eof, gat_hact;

    assign line_start = hact_in & ~hact_d;
    assign vact_rise  = vact_in & ~vact_d;
    assign vact_fall  = ~vact_in & vact_d;
    assign last_word  = (phase == 2'd3) && (wcnt == 2'd3);
    assign emit       = (state != ST_IDLE) && (phase == 2'd2);
    assign busy       = (state != ST_IDLE);

    // Pixels of a rejected line never enter the delay line.
    assign gat_hact = hact_in & (line_start ? (state == ST_IDLE) : line_acc);

    assign hdr_code_nxt = ((first_line | vact_rise) ? CODE_SOF : CODE_SOL)
                        | (embed ? (12'd1 << EMBED_BIT) : 12'd0);

    sens_hispi_enc_gather #(
        .NUMLANES (NUMLANES),
        .PXD_DLY  (PXD_DLY)
    ) u_gather (
        .ipclk    (pclk),
        .irst     (prst),
        .pxd      (pxd_in),
        .hact     (gat_hact),
        .grp_clr  (emit && (state == ST_DATA)),
        .grp      (grp),
        .dly_hact (dly_hact)
    );

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_hdr = 1'b0;
        start_eof = 1'b0;
        word_nxt  = lane_dout;
        case (state)
            ST_IDLE: begin
                if (line_start) begin
                    state_nxt = ST_HDR;
                    start_hdr = 1'b1;
                end else if (eof_pend) begin
                    state_nxt = ST_EOFP;
                    start_eof = 1'b1;
                end
            end
            ST_HDR: begin
                word_nxt = {NUMLANES{ctl_word(wcnt, hdr_code)}};
                if (last_word) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                word_nxt = grp;
                // In a strobe slot the delayed stream already shows the next group's first pixel.
                if ((phase == 2'd3) && !dly_hact) state_nxt = ST_TRL;
            end
            ST_TRL: begin
                word_nxt = {NUMLANES{ctl_word(wcnt, CODE_EOL)}};
                if (last_word) state_nxt = eof_pend ? ST_EOFP : ST_IDLE;
            end
            ST_EOFP: begin
                word_nxt = {NUMLANES{ctl_word(wcnt, CODE_EOF)}};
                if (last_word) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            phase      <= 2'd0;
            wcnt       <= 2'd0;
            hact_d     <= 1'b0;
            vact_d     <= 1'b0;
            first_line <= 1'b0;
            eof_pend   <= 1'b0;
            line_acc   <= 1'b0;
            hdr_code   <= '0;
            lane_dout  <= '0;
            wstb       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            phase  <= (start_hdr || start_eof) ? 2'd0 : phase + 2'd1;
            wcnt   <= (state_nxt != state) ? 2'd0 :
                      (phase == 2'd3)      ? wcnt + 2'd1 : wcnt;
            hact_d <= hact_in;
            vact_d <= vact_in;

            if (start_hdr)      first_line <= 1'b0;
            else if (vact_rise) first_line <= 1'b1;

            if (vact_fall)                              eof_pend <= 1'b1;
            else if ((state == ST_EOFP) && last_word)   eof_pend <= 1'b0;

            if (line_start) line_acc <= (state == ST_IDLE);
            if (start_hdr)  hdr_code <= hdr_code_nxt;
            if (line_start && (state != ST_IDLE)) overrun <= 1'b1;

            wstb <= emit;
            if (emit) lane_dout <= word_nxt;
        end
    end

endmodule
